// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: boolean constants,
// controller state encoding and the fetch-address field widths.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ADDR_BITS             = 32;
    localparam int WORD_BITS             = 32;
    localparam int BYTE_OFFSET_BITS      = 2;
    localparam int DEF_INDEX_BITS        = 6;
    localparam int DEF_OFFSET_WORDS_BITS = 2;

    typedef enum logic [1:0] {
        ICACHE_IDLE     = 2'd0,
        ICACHE_COOL     = 2'd1,
        ICACHE_FILL_REQ = 2'd2,
        ICACHE_FILL_GAP = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the instruction cache: combinational read by (index, offset),
// one write port that can store a word, install a tag (setting valid) or clear a valid bit.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS        = DEF_INDEX_BITS,
    parameter int OFFSET_WORDS_BITS = DEF_OFFSET_WORDS_BITS,
    parameter int TAG_BITS          = ADDR_BITS - INDEX_BITS - OFFSET_WORDS_BITS - BYTE_OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INDEX_BITS-1:0]        rd_idx,
    input  logic [OFFSET_WORDS_BITS-1:0] rd_off,
    output logic                         rd_valid,
    output logic [TAG_BITS-1:0]          rd_tag,
    output logic [WORD_BITS-1:0]         rd_word,
    input  logic [INDEX_BITS-1:0]        wr_idx,
    input  logic [OFFSET_WORDS_BITS-1:0] wr_off,
    input  logic                         wr_word_en,
    input  logic [WORD_BITS-1:0]         wr_word,
    input  logic                         wr_tag_en,
    input  logic [TAG_BITS-1:0]          wr_tag,
    input  logic                         clr_valid
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = LINES << OFFSET_WORDS_BITS;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [WORD_BITS-1:0] data_mem [WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_word  = data_mem[{rd_idx, rd_off}];

    always_comb begin
        // NOTE: assign the default before any conditional update so no path can infer a latch.
        valid_d = valid_q;
        if (clr_valid) begin
            valid_d[wr_idx] = FALSE;
        end else if (wr_tag_en) begin
            valid_d[wr_idx] = TRUE;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid_q alone gates their use.
    always_ff @(posedge clk) begin
        if (wr_word_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_word;
        end
        if (wr_tag_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: answers fetch requests on a hit and refills a whole
// line from the memory controller, one word per read transaction, on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS        = DEF_INDEX_BITS,
    parameter int OFFSET_WORDS_BITS = DEF_OFFSET_WORDS_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 IC_flag,
    input  logic [ADDR_BITS-1:0] IC_PC,
    output logic                 IC_commit,
    output logic [WORD_BITS-1:0] IC_val,
    output logic                 MC_flag,
    output logic [ADDR_BITS-1:0] MC_addr,
    input  logic                 MC_commit,
    input  logic [WORD_BITS-1:0] MC_val
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_WORDS_BITS - BYTE_OFFSET_BITS;
    localparam int IDX_LO   = BYTE_OFFSET_BITS + OFFSET_WORDS_BITS;
    localparam logic [OFFSET_WORDS_BITS-1:0] LAST_WORD = '1;

    icache_state_e state_q, state_d;

    logic                         ic_commit_q, ic_commit_d;
    logic [WORD_BITS-1:0]         ic_val_q,    ic_val_d;
    logic                         mc_flag_q,   mc_flag_d;
    logic [ADDR_BITS-1:0]         mc_addr_q,   mc_addr_d;
    logic [OFFSET_WORDS_BITS-1:0] counter_q,   counter_d;
    logic [TAG_BITS-1:0]          fill_tag_q,  fill_tag_d;
    logic [INDEX_BITS-1:0]        fill_idx_q,  fill_idx_d;

    logic [TAG_BITS-1:0]          pc_tag;
    logic [INDEX_BITS-1:0]        pc_idx;
    logic [OFFSET_WORDS_BITS-1:0] pc_off;
    logic                         unused_byte_bits;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [WORD_BITS-1:0]  rd_word;
    logic                  hit;
    logic                  last_word;
    logic [INDEX_BITS-1:0] wr_idx;
    logic                  wr_word_en;
    logic                  wr_tag_en;
    logic                  clr_valid;

    assign pc_tag           = IC_PC[ADDR_BITS-1 -: TAG_BITS];
    assign pc_idx           = IC_PC[IDX_LO +: INDEX_BITS];
    assign pc_off           = IC_PC[BYTE_OFFSET_BITS +: OFFSET_WORDS_BITS];
    assign unused_byte_bits = ^IC_PC[BYTE_OFFSET_BITS-1:0];

    assign hit       = rd_valid && (rd_tag == pc_tag);
    assign last_word = (counter_q == LAST_WORD);

    icache_array #(
        .INDEX_BITS        (INDEX_BITS),
        .OFFSET_WORDS_BITS (OFFSET_WORDS_BITS),
        .TAG_BITS          (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (pc_idx),
        .rd_off     (pc_off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_word    (rd_word),
        .wr_idx     (wr_idx),
        .wr_off     (counter_q),
        .wr_word_en (wr_word_en),
        .wr_word    (MC_val),
        .wr_tag_en  (wr_tag_en),
        .wr_tag     (fill_tag_q),
        .clr_valid  (clr_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ICACHE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                ICACHE_IDLE:     if (IC_flag) state_d = hit ? ICACHE_COOL : ICACHE_FILL_REQ;
                ICACHE_COOL:     state_d = ICACHE_IDLE;
                ICACHE_FILL_REQ: if (MC_commit) state_d = last_word ? ICACHE_IDLE : ICACHE_FILL_GAP;
                ICACHE_FILL_GAP: state_d = ICACHE_FILL_REQ;
                default:         state_d = ICACHE_IDLE;
            endcase
        end
    end

    // With rdy low everything holds except IC_commit, which defaults to low.
    always_comb begin
        ic_commit_d = FALSE;
        ic_val_d    = ic_val_q;
        mc_flag_d   = mc_flag_q;
        mc_addr_d   = mc_addr_q;
        counter_d   = counter_q;
        fill_tag_d  = fill_tag_q;
        fill_idx_d  = fill_idx_q;
        wr_idx      = fill_idx_q;
        wr_word_en  = FALSE;
        wr_tag_en   = FALSE;
        clr_valid   = FALSE;
        if (rdy) begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (IC_flag && hit) begin
                        ic_commit_d = TRUE;
                        ic_val_d    = rd_word;
                    end else if (IC_flag) begin
                        fill_tag_d = pc_tag;
                        fill_idx_d = pc_idx;
                        wr_idx     = pc_idx;
                        clr_valid  = TRUE;
                        counter_d  = '0;
                        mc_flag_d  = TRUE;
                        mc_addr_d  = {pc_tag, pc_idx, {IDX_LO{1'b0}}};
                    end
                end
                ICACHE_FILL_REQ: begin
                    if (MC_commit) begin
                        wr_word_en = TRUE;
                        mc_flag_d  = FALSE;
                        if (last_word) begin
                            wr_tag_en = TRUE;
                        end else begin
                            counter_d = counter_q + 1'b1;
                        end
                    end
                end
                ICACHE_FILL_GAP: begin
                    mc_flag_d = TRUE;
                    mc_addr_d = {fill_tag_q, fill_idx_q, counter_q, {BYTE_OFFSET_BITS{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_commit_q <= FALSE;
            ic_val_q    <= '0;
            mc_flag_q   <= FALSE;
            mc_addr_q   <= '0;
            counter_q   <= '0;
            fill_tag_q  <= '0;
            fill_idx_q  <= '0;
        end else begin
            ic_commit_q <= ic_commit_d;
            ic_val_q    <= ic_val_d;
            mc_flag_q   <= mc_flag_d;
            mc_addr_q   <= mc_addr_d;
            counter_q   <= counter_d;
            fill_tag_q  <= fill_tag_d;
            fill_idx_q  <= fill_idx_d;
        end
    end

    assign IC_commit = ic_commit_q;
    assign IC_val    = ic_val_q;
    assign MC_flag   = mc_flag_q;
    assign MC_addr   = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios plus a randomized request stream checked
// against a line-level cache model and a fixed backing-memory function.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IC_flag;
    logic [31:0] IC_PC;
    logic        IC_commit;
    logic [31:0] IC_val;
    logic        MC_flag;
    logic [31:0] MC_addr;
    logic        MC_commit;
    logic [31:0] MC_val;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mc_log[$];
    logic        mc_enable;
    time         t_last_mc;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .IC_flag   (IC_flag),
        .IC_PC     (IC_PC),
        .IC_commit (IC_commit),
        .IC_val    (IC_val),
        .MC_flag   (MC_flag),
        .MC_addr   (MC_addr),
        .MC_commit (MC_commit),
        .MC_val    (MC_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'd0) begin
            case (a[3:2])
                2'd0:    return 32'h0000_0011;
                2'd1:    return 32'h0000_0022;
                2'd2:    return 32'h0000_0033;
                default: return 32'h0000_0044;
            endcase
        end
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc);
        IC_PC   = pc;
        IC_flag = 1'b1;
    endtask

    // Waits for a commit, then drops the flag (immediately, or after the cool cycle if hold).
    task automatic wait_commit(input string tag, input bit hold, output int cycles,
                               output logic [31:0] val, output time t_seen);
        bit got;
        got    = 1'b0;
        cycles = 0;
        val    = '0;
        t_seen = 0;
        while (!got && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (IC_commit === 1'b1) begin
                got    = 1'b1;
                val    = IC_val;
                t_seen = $time;
            end
        end
        check({tag, "_seen"}, {31'b0, got}, 32'd1);
        if (!hold) IC_flag = 1'b0;
        @(negedge clk);
        check({tag, "_one_pulse"}, {31'b0, IC_commit}, 32'd0);
        if (hold) begin
            IC_flag = 1'b0;
            @(negedge clk);
            check({tag, "_after_cool"}, {31'b0, IC_commit}, 32'd0);
        end
    endtask

    task automatic check_fill(input string tag, input logic [31:0] base);
        check({tag, "_mc_count"}, 32'(mc_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_mc_addr"}, (k < mc_log.size()) ? mc_log[k] : 32'hDEAD_BEEF,
                  base + 32'(4 * k));
        end
    endtask

    // Memory-controller responder with random latency; also watches fill-time invariants.
    initial begin : mc_responder
        int lat;
        lat       = 0;
        MC_commit = 1'b0;
        MC_val    = '0;
        t_last_mc = 0;
        forever begin
            @(negedge clk);
            if (MC_commit) begin
                MC_commit = 1'b0;
                check("mc_flag_gap", {31'b0, MC_flag}, 32'd0);
            end else if (mc_enable && rdy && !rst && MC_flag === 1'b1) begin
                if (lat == 0) begin
                    MC_commit = 1'b1;
                    MC_val    = mem_word(MC_addr);
                    mc_log.push_back(MC_addr);
                    t_last_mc = $time;
                    lat       = $urandom_range(0, 2);
                end else begin
                    lat--;
                end
            end
            if (MC_flag === 1'b1) check("no_commit_during_fill", {31'b0, IC_commit}, 32'd0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int          cyc;
        int          n_commit;
        logic [31:0] val;
        time         t_seen;
        bit          m_valid [64];
        logic [21:0] m_tag   [64];

        rst = 1'b1; rdy = 1'b1; IC_flag = 1'b0; IC_PC = '0; mc_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ic_commit", {31'b0, IC_commit}, 32'd0);
        check("rst_ic_val",    IC_val,             32'd0);
        check("rst_mc_flag",   {31'b0, MC_flag},   32'd0);
        check("rst_mc_addr",   MC_addr,            32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss on line 0.
        mc_log.delete();
        issue(32'h0000_0000);
        wait_commit("cold", 1'b0, cyc, val, t_seen);
        check("cold_val", val, 32'h0000_0011);
        check_fill("cold", 32'h0000_0000);
        check("cold_latency", 32'(t_seen - t_last_mc), 32'd20);

        // Hit with the flag held through the cool cycle.
        mc_log.delete();
        issue(32'h0000_0008);
        wait_commit("hit8", 1'b1, cyc, val, t_seen);
        check("hit8_cycles", 32'(cyc), 32'd1);
        check("hit8_val", val, 32'h0000_0033);
        check("hit8_no_mc", 32'(mc_log.size()), 32'd0);

        // Conflict: same index, new tag.
        mc_log.delete();
        issue(32'h0000_0400);
        wait_commit("conflict", 1'b0, cyc, val, t_seen);
        check("conflict_val", val, mem_word(32'h0000_0400));
        check_fill("conflict", 32'h0000_0400);

        // Requester jumps away mid-fill.
        mc_log.delete();
        issue(32'h0000_2040);
        repeat (3) @(negedge clk);
        IC_flag  = 1'b0;
        IC_PC    = 32'h0000_5000;
        n_commit = 0;
        cyc      = 0;
        while (!(mc_log.size() == 4 && MC_flag === 1'b0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (IC_commit === 1'b1) n_commit++;
        end
        repeat (3) begin
            @(negedge clk);
            if (IC_commit === 1'b1) n_commit++;
        end
        check("jump_no_commit", 32'(n_commit), 32'd0);
        check_fill("jump", 32'h0000_2040);
        mc_log.delete();
        issue(32'h0000_2048);
        wait_commit("jump_hit", 1'b0, cyc, val, t_seen);
        check("jump_hit_cycles", 32'(cyc), 32'd1);
        check("jump_hit_val", val, mem_word(32'h0000_2048));

        // rdy low for three cycles while the read is outstanding.
        mc_enable = 1'b0;
        mc_log.delete();
        issue(32'h0000_1230);
        @(negedge clk);
        check("rdy_mc_flag_up", {31'b0, MC_flag}, 32'd1);
        check("rdy_mc_addr_up", MC_addr, 32'h0000_1230);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rdy_hold_flag",   {31'b0, MC_flag},   32'd1);
            check("rdy_hold_addr",   MC_addr,            32'h0000_1230);
            check("rdy_hold_commit", {31'b0, IC_commit}, 32'd0);
        end
        rdy       = 1'b1;
        mc_enable = 1'b1;
        wait_commit("rdy_fill", 1'b0, cyc, val, t_seen);
        check("rdy_fill_val", val, mem_word(32'h0000_1230));
        check_fill("rdy_fill", 32'h0000_1230);
        for (int k = 1; k < 4; k++) begin
            issue(32'h0000_1230 + 32'(4 * k));
            wait_commit("rdy_line_hit", 1'b0, cyc, val, t_seen);
            check("rdy_line_hit_cycles", 32'(cyc), 32'd1);
            check("rdy_line_hit_val", val, mem_word(32'h0000_1230 + 32'(4 * k)));
        end

        // Line 0 now holds 0x400, so 0x0 misses; reset after two fill words.
        mc_log.delete();
        issue(32'h0000_0000);
        @(negedge clk);
        check("miss_again_flag", {31'b0, MC_flag}, 32'd1);
        check("miss_again_addr", MC_addr, 32'h0000_0000);
        cyc = 0;
        while (mc_log.size() < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        mc_enable = 1'b0;
        check("rst_fill_words", 32'(mc_log.size()), 32'd2);
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        IC_flag = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midfill_rst_mc_flag",   {31'b0, MC_flag},   32'd0);
        check("midfill_rst_mc_addr",   MC_addr,            32'd0);
        check("midfill_rst_ic_commit", {31'b0, IC_commit}, 32'd0);
        check("midfill_rst_ic_val",    IC_val,             32'd0);
        mc_enable = 1'b1;
        mc_log.delete();
        issue(32'h0000_0000);
        wait_commit("post_rst_0", 1'b0, cyc, val, t_seen);
        check("post_rst_0_val", val, 32'h0000_0011);
        check_fill("post_rst_0", 32'h0000_0000);
        mc_log.delete();
        issue(32'h0000_2044);
        wait_commit("post_rst_2044", 1'b0, cyc, val, t_seen);
        check("post_rst_2044_val", val, mem_word(32'h0000_2044));
        check_fill("post_rst_2044", 32'h0000_2040);

        // Randomized requests over a few conflicting tags against a line-level model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        for (int i = 0; i < 40; i++) begin
            int          t;
            int          idx;
            logic [31:0] pc;
            bit          exp_hit;
            t       = $urandom_range(0, 2);
            idx     = $urandom_range(0, 3);
            pc      = (32'(t) << 10) | (32'(idx) << 4) | (32'($urandom_range(0, 3)) << 2);
            exp_hit = m_valid[idx] && (m_tag[idx] == 22'(t));
            mc_log.delete();
            issue(pc);
            wait_commit("rand", 1'b0, cyc, val, t_seen);
            check("rand_val", val, mem_word(pc));
            if (exp_hit) begin
                check("rand_hit_cycles", 32'(cyc), 32'd1);
                check("rand_hit_no_mc", 32'(mc_log.size()), 32'd0);
            end else begin
                check_fill("rand_miss", pc & 32'hFFFF_FFF0);
                check("rand_miss_latency", 32'(t_seen - t_last_mc), 32'd20);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = 22'(t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache; the responder on the fetch request interface. The fetch stage drives IC_flag/IC_PC; this block returns IC_commit/IC_val.
- On a miss it refills a whole line from the memory controller, one 32-bit word per read transaction.
- Sits between the fetch stage and the memory-controller instruction-read port.

Parameters:
- INDEX_BITS, 6, line index width (64 lines).
- OFFSET_WORDS_BITS, 2, log2 of words per line (4 words = 16 B).
- TAG_BITS, 32-INDEX_BITS-OFFSET_WORDS_BITS-2, tag width; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low freezes the block.
- IC_flag  in  1  fetch request, level; held by requester until a commit is sampled.
- IC_PC  in  32  fetch address, word aligned (bits [1:0] ignored).
- IC_commit  out  1  one-cycle response pulse; IC_val is valid in the same cycle.
- IC_val  out  32  instruction word for IC_PC.
- MC_flag  out  1  memory read request, level; held until MC_commit.
- MC_addr  out  32  word address of the read.
- MC_commit  in  1  one-cycle pulse; read data valid.
- MC_val  in  32  read data.

Behaviour:
- Address split: [1:0] byte, [3:2] word offset, [9:4] index, [31:10] tag.
- Storage: valid[64], tag[64], data[64][4] words. Only the valid bits are reset.
- Reset: all valid=0, state=IDLE, IC_commit=0, IC_val=0, MC_flag=0, MC_addr=0, word counter=0. Reset mid-fill abandons the fill immediately.
- rdy=0: state, counter, arrays and MC_flag/MC_addr hold. IC_commit is forced 0 that cycle.
- All outputs are registered.
- States and transitions:
  - IDLE, IC_flag=1, hit (valid && tag match): IC_commit<=1, IC_val<=data[idx][off]; go to COOL.
  - IDLE, IC_flag=1, miss: latch tag/index into the fill registers; valid[idx]<=0; counter<=0; MC_flag<=1; MC_addr<={tag,idx,4'b0000}; go to FILL_REQ.
  - IDLE, IC_flag=0: stay.
  - COOL: IC_commit<=0; ignore IC_flag for this one cycle, because the requester is still dropping its flag; go to IDLE.
  - FILL_REQ, MC_commit=1: data[fill_idx][counter]<=MC_val; MC_flag<=0.
    - counter=3: tag[fill_idx]<=fill_tag, valid[fill_idx]<=1; go to IDLE.
    - otherwise: counter<=counter+1; go to FILL_GAP.
  - FILL_REQ, MC_commit=0: hold MC_flag/MC_addr.
  - FILL_GAP: MC_flag<=1, MC_addr<={fill_tag,fill_idx,counter,2'b00}; go to FILL_REQ. This guarantees at least one flag-low cycle between reads.
- Hit latency: IC_commit asserts in the cycle after the first IDLE cycle that sees IC_flag with a hit.
- Miss latency: 4 MC transactions, then one IDLE cycle of hit lookup, then IC_commit. The requested word is never forwarded early.
- No IC_commit is ever produced in FILL_REQ/FILL_GAP. A redirect or flag drop during a fill is therefore harmless.
- The fill always completes; there is no abort input.
- After a fill, if IC_flag is low or IC_PC has changed, IDLE simply re-evaluates the new request.
- A requester that ignores a commit (queue full) re-requests later and hits.
- The line being filled never hits, because its valid bit is cleared at miss start.
- IC_PC changing while IC_flag=1 in IDLE: the lookup uses the current value each cycle.

Decomposition:
- Shared define file: TRUE/FALSE, the state encodings ICACHE_IDLE/COOL/FILL_REQ/FILL_GAP, and the address field widths.
- Sub-module icache_array: tag/valid/data storage with a combinational read port (index, offset) and a single write port (word write; tag+valid write; valid clear). The FSM stays in icache.

Test Plan:
- Cold miss at IC_PC=0x00000000, MC returns 0x11,0x22,0x33,0x44:
  - MC_addr sequence 0x0,0x4,0x8,0xC, each separated by ≥1 MC_flag-low cycle;
  - then IC_commit=1 with IC_val=0x11 exactly one cycle after the last MC_commit+IDLE;
  - IC_commit is high for exactly one cycle.
- Hit after fill, IC_flag held at 0x00000008 → IC_commit on the 2nd cycle with IC_val=0x33. A COOL cycle follows, with no second commit even though IC_flag is still high during COOL.
- Conflict at 0x00000400 (same index 0, new tag) → a new 4-word fill at 0x400..0x40C. A later request to 0x0 misses again.
- Requester drops IC_flag mid-fill (jump) → the fill still completes, IC_commit stays 0 throughout; a later request to the same line hits in 2 cycles.
- rdy=0 for 3 cycles while MC_flag=1 → MC_flag/MC_addr hold and IC_commit=0. The fill resumes on rdy=1 with no lost or duplicated words.
- rst pulsed after 2 fill words → MC_flag=0, state IDLE, all valid=0; a request to 0x0 restarts the fill from MC_addr 0x0.
